// File: rtl/lelbc_block_packer.sv
// Byte-to-block framer for the LELBC encrypt datapath.
// Packs bytes MSB-first into 64-bit blocks and appends 0x80/0x00 padding.
module lelbc_block_packer #(
    parameter logic [7:0] PAD_BYTE  = 8'h80,
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [0:63] m_block,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        busy
);

    typedef enum logic {FILL, PAD} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [0:63] acc_q, acc_d;
    logic [0:63] ob_q, ob_d;
    logic        ov_q, ov_d;
    logic        ol_q, ol_d;
    logic [0:63] blk;
    logic        ob_free;
    logic        s_fire;
    logic        stay;

    assign ob_free = !ov_q || m_ready;
    assign stay    = (cnt_q != 3'd7) && !s_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ob_d    = ob_q;
        ov_d    = ov_q;
        ol_d    = ol_q;
        s_ready = 1'b0;
        s_fire  = 1'b0;
        blk     = acc_q;
        blk[{cnt_q, 3'b000} +: 8] = s_data;
        if (ov_q && m_ready) begin
            ov_d = 1'b0;
        end
        unique case (state_q)
            FILL: begin
                // Block-closing bytes wait until the output slot can take them
                s_ready = rst_n && (stay || ob_free);
                s_fire  = s_valid && s_ready;
                if (s_fire) begin
                    if (stay) begin
                        acc_d = blk;
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        if (s_last && cnt_q != 3'd7) begin
                            for (int i = 1; i < 8; i++) begin
                                if (3'(i) > cnt_q) begin
                                    blk[{3'(i), 3'b000} +: 8] =
                                        (3'(i) == cnt_q + 3'd1) ?
                                        PAD_BYTE : FILL_BYTE;
                                end
                            end
                        end
                        ob_d  = blk;
                        ov_d  = 1'b1;
                        ol_d  = s_last && (cnt_q != 3'd7);
                        cnt_d = 3'd0;
                        acc_d = '0;
                        if (s_last && cnt_q == 3'd7) begin
                            state_d = PAD;
                        end
                    end
                end
            end
            PAD: begin
                if (ob_free) begin
                    ob_d    = {PAD_BYTE, {7{FILL_BYTE}}};
                    ov_d    = 1'b1;
                    ol_d    = 1'b1;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= 3'd0;
            acc_q   <= '0;
            ob_q    <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ob_q    <= ob_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
        end
    end

    assign m_block = ob_q;
    assign m_valid = ov_q;
    assign m_last  = ol_q;
    assign busy    = (cnt_q != 3'd0) || (state_q == PAD);

endmodule

// File: tb/tb_lelbc_block_packer.sv
// Randomized and directed bench for lelbc_block_packer.
// Reference model pads whole messages and checks blocks in order.
module tb_lelbc_block_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [0:63] m_block;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        busy;

    int n_tests = 0;
    int n_fail = 0;
    int mode = 3;
    int nblk = 0;
    int nlast = 0;

    logic [7:0]  cur[$];
    logic [64:0] expq[$];
    logic        have_prev = 1'b0;
    logic [63:0] prev_blk;
    logic        prev_last;

    lelbc_block_packer dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready),
        .m_block(m_block), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // m_ready pattern: 0 always, 1 toggle, 2 random, 3 held low
    always @(posedge clk) begin
        #1;
        case (mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    function automatic logic [63:0] pack(input logic [7:0] b[$]);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v[63 - 8*i -: 8] = b[i];
        return v;
    endfunction

    // Reference: a message is its bytes, then 0x80, then 0x00 to a multiple of 8
    always @(negedge clk) begin
        if (!rst_n) begin
            cur.delete();
            expq.delete();
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                check("hold_blk", m_block, prev_blk);
                check("hold_last", 64'(m_last), 64'(prev_last));
            end
            have_prev = m_valid && !m_ready;
            prev_blk  = m_block;
            prev_last = m_last;
            if (m_valid && m_ready) begin
                logic [64:0] e;
                nblk++;
                if (m_last) nlast++;
                if (expq.size() == 0) begin
                    check("extra_blk", m_block, 64'hx);
                end else begin
                    e = expq.pop_front();
                    check("blk", m_block, e[63:0]);
                    check("last", 64'(m_last), 64'(e[64]));
                end
            end
            if (s_valid && s_ready) begin
                cur.push_back(s_data);
                if (s_last) begin
                    cur.push_back(8'h80);
                    while (cur.size() % 8 != 0) cur.push_back(8'h00);
                    while (cur.size() > 0) begin
                        expq.push_back({cur.size() == 8, pack(cur)});
                        repeat (8) void'(cur.pop_front());
                    end
                end else if (cur.size() == 8) begin
                    expq.push_back({1'b0, pack(cur)});
                    cur.delete();
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic l, input int bound);
        int w = 0;
        s_data  = b;
        s_last  = l;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            w++;
            if (w >= bound) begin
                check("send_tmo", 64'(w), 64'(bound - 1));
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int w = 0;
        forever begin
            @(negedge clk);
            if (!m_valid && !busy) break;
            w++;
            if (w >= bound) begin
                check("idle_tmo", 64'(w), 64'(bound - 1));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nb0, nl0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_block", m_block, 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sready", 64'(s_ready), 64'd0);
        mode = 0;
        #19 rst_n = 1'b1;
        #1;
        check("rel_sready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8, 20);
        check("t1_blk", m_block, 64'h0102030405060708);
        check("t1_valid", 64'(m_valid), 64'd1);
        check("t1_last", 64'(m_last), 64'd0);
        check("t1_pad_srdy", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        check("t1_pad_blk", m_block, 64'h8000000000000000);
        check("t1_pad_last", 64'(m_last), 64'd1);
        wait_idle(20);

        send_byte(8'hAA, 1'b0, 20);
        send_byte(8'hBB, 1'b0, 20);
        send_byte(8'hCC, 1'b1, 20);
        check("t2_blk", m_block, 64'hAABBCC8000000000);
        check("t2_last", 64'(m_last), 64'd1);
        check("t2_busy", 64'(busy), 64'd0);
        wait_idle(20);

        mode = 3;
        fork
            begin
                for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15, 100);
                check("t3_blk2", m_block, 64'h08090A0B0C0D0E0F);
                check("t3_valid2", 64'(m_valid), 64'd1);
            end
            begin
                repeat (20) @(posedge clk);
                #2;
                check("t3_hold", m_block, 64'h0001020304050607);
                check("t3_stall", 64'(s_ready), 64'd0);
                check("t3_busy", 64'(busy), 64'd1);
                mode = 0;
            end
        join
        wait_idle(20);

        send_byte(8'h5A, 1'b1, 20);
        check("t4_blk", m_block, 64'h5A80000000000000);
        check("t4_last", 64'(m_last), 64'd1);
        wait_idle(20);

        mode = 3;
        for (int i = 0; i < 11; i++) send_byte(8'(8'hA0 + i), 1'b0, 20);
        check("t5_pre_valid", 64'(m_valid), 64'd1);
        check("t5_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(m_valid), 64'd0);
        check("t5_rst_block", m_block, 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        mode = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i), 1'b0, 20);
        check("t5_blk", m_block, 64'h1112131415161718);
        check("t5_last", 64'(m_last), 64'd0);
        wait_idle(20);

        mode = 1;
        nb0 = nblk;
        nl0 = nlast;
        for (int i = 0; i < 24; i++) send_byte(8'($urandom), i == 23, 20);
        wait_idle(20);
        check("t6_nblk", 64'(nblk - nb0), 64'd4);
        check("t6_nlast", 64'(nlast - nl0), 64'd1);

        mode = 2;
        for (int m = 0; m < 30; m++) begin
            int len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                send_byte(8'($urandom), i == len - 1, 50);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        mode = 0;
        wait_idle(50);
        check("rand_drain", 64'(expq.size()), 64'd0);
        check("rand_partial", 64'(cur.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
